fifo_wr_skid: RTL and testbench
===============================

FIFO_WR_SKID -- requirements
Module: fifo_wr_skid

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data word width in bits.
REQ-002 SHALL have parameter CNTW, default 16: width of the word and packet counters.
REQ-003 SHALL have port wclk  input  1: write-domain clock; all logic on its rising edge.
REQ-004 SHALL have port wrst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port s_valid  input  1: upstream word valid.
REQ-006 SHALL have port s_ready  output  1: block can accept a word this cycle.
REQ-007 SHALL have port s_data  input  DSIZE: upstream word.
REQ-008 SHALL have port s_last  input  1: word ends a packet.
REQ-009 SHALL have port wfull  input  1: registered FIFO-full flag from the write-pointer/full stage.
REQ-010 SHALL have port winc  output  1: write strobe to the FIFO write-pointer stage and memory.
REQ-011 SHALL have port wdata  output  DSIZE: data word to FIFO memory, valid when winc=1.
REQ-012 SHALL have port wr_words  output  CNTW: count of words written to the FIFO.
REQ-013 SHALL have port wr_pkts  output  CNTW: count of packets written to the FIFO (words with last written).
REQ-014 SHALL have port err_ovf  output  1: sticky protocol error flag.

Function
REQ-015 SHALL hold two registered entries:
- main: out_valid, out_data, out_last
- skid: skid_valid, skid_data, skid_last
REQ-016 SHALL drive s_ready = ~skid_valid, directly from a register with no combinational path from wfull or s_valid.
REQ-017 SHALL define accept = s_valid & s_ready, and pop = out_valid & ~wfull.
REQ-018 SHALL drive winc = pop and wdata = out_data.
REQ-019 SHALL, when skid_valid=1 and pop=1:
- load main from skid, with out_valid remaining 1
- clear skid_valid
REQ-020 SHALL, when skid_valid=1 and pop=0, hold both entries unchanged.
REQ-021 SHALL, when skid_valid=0 and accept=1 with out_valid=1 and pop=0, load skid from s_data/s_last and set skid_valid.
REQ-022 SHALL, when skid_valid=0 and accept=1 otherwise, load main from s_data/s_last and set out_valid.
REQ-023 SHALL, when skid_valid=0, accept=0 and pop=1, clear out_valid.
REQ-024 SHALL present a word accepted in cycle N on winc no earlier than cycle N+1; latency is exactly 1 cycle when the FIFO is not full and the skid entry is empty.
REQ-025 SHALL sustain one word per cycle (winc=1 every cycle) while s_valid=1 and wfull=0.
REQ-026 SHALL preserve word order; no word is ever dropped or duplicated.
REQ-027 SHALL keep main and skid contents stable while wfull=1; s_ready falls the cycle after skid fills.
REQ-028 SHALL increment wr_words by 1 on every pop, wrapping modulo 2^CNTW.
REQ-029 SHALL increment wr_pkts by 1 on every pop with out_last=1, wrapping modulo 2^CNTW.
REQ-030 SHALL set err_ovf when winc=1 and wfull=1 in the same cycle; it holds until reset. This is unreachable by design and serves as an assertion hook.
REQ-031 SHALL treat s_data/s_last as don't-care when s_valid=0, and SHALL NOT require s_valid to stay asserted without s_ready.

Reset
REQ-032 SHALL, on wrst_n=0, asynchronously clear out_valid, skid_valid, wr_words, wr_pkts and err_ovf; data registers need no reset.
REQ-033 SHALL produce the following while wrst_n=0:
- s_ready=1
- winc=0
- wr_words=0
- wr_pkts=0
- err_ovf=0
REQ-034 SHALL, on reset assertion mid-transfer, discard both held words, with no winc in or after the reset cycle until new data is accepted.
REQ-035 SHALL accept a word in the first wclk edge after wrst_n deasserts.

Verification
REQ-036 Streaming: s_valid=1 with data 0x01..0x10, last on 0x10, wfull=0 -> winc high on 16 consecutive cycles starting 1 cycle after the first accept; wdata 0x01..0x10 in order; wr_words=16; wr_pkts=1.
REQ-037 Backpressure: stream 0xA0..0xA3 with wfull=1 from the first accept -> s_ready=0 after 2 words; winc=0; release wfull -> 0xA0,0xA1,0xA2,0xA3 written in order with no loss.
REQ-038 Simultaneous accept and pop: wfull toggling every cycle with continuous s_valid -> no word lost or duplicated; err_ovf stays 0; wr_words equals the number of winc pulses.
REQ-039 Reset mid-operation: both entries full with wfull=1, then wrst_n pulsed low -> s_ready=1, winc=0, wr_words=0 immediately; the first post-reset word 0x5A appears on wdata 1 cycle after accept.
REQ-040 Counter wrap: CNTW=4, 17 single-word packets -> wr_words=1, wr_pkts=1.
REQ-041 Integrated with the write-pointer/full stage at ADDRSIZE=4 and the read side stalled -> exactly 16 words written, then wfull=1, winc=0, s_ready=0; err_ovf=0.

Source files
------------

// File: rtl/fifo_wr_skid.sv
// Purpose: two-entry (main + skid) write-side register slice ahead of an async FIFO, with word/packet counters.
// Latency: a word accepted in cycle N drives winc/wdata in cycle N+1 when the skid entry is empty and wfull=0.
// Backpressure: s_ready is the inverted skid-valid flop; it falls one cycle after the skid entry fills.
module fifo_wr_skid #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic [CNTW-1:0]  wr_words,
    output logic [CNTW-1:0]  wr_pkts,
    output logic             err_ovf
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Main entry: the word currently offered to the FIFO.
    logic             out_valid_q, out_valid_d;
    logic [DSIZE-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;

    // Skid entry: catches the one word accepted while main is stalled.
    logic             skid_valid_q, skid_valid_d;
    logic [DSIZE-1:0] skid_data_q,  skid_data_d;
    logic             skid_last_q,  skid_last_d;

    // Statistics and sticky error.
    logic [CNTW-1:0]  wr_words_q, wr_words_d;
    logic [CNTW-1:0]  wr_pkts_q,  wr_pkts_d;
    logic             err_ovf_q,  err_ovf_d;

    logic             accept;
    logic             pop;

    // Handshake terms; s_ready depends only on a flop so upstream sees no comb path from wfull.
    always_comb begin
        s_ready = ~skid_valid_q;
        accept  = s_valid & ~skid_valid_q;
        pop     = out_valid_q & ~wfull;
        winc    = pop;
        wdata   = out_data_q;
    end

    // Main/skid next-state: drain skid first, otherwise accept into whichever entry is free.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;

        if (skid_valid_q) begin
            // s_ready is low here, so no new word can arrive; only a pop moves data.
            if (pop) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q && !pop) begin
                // Main is stuck this cycle: park the new word in skid.
                skid_data_d  = s_data;
                skid_last_d  = s_last;
                skid_valid_d = 1'b1;
            end else begin
                // Main is empty or emptying: new word goes straight to main.
                out_data_d   = s_data;
                out_last_d   = s_last;
                out_valid_d  = 1'b1;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Counters advance on each word handed to the FIFO; wrap naturally at 2^CNTW.
    always_comb begin
        wr_words_d = wr_words_q;
        wr_pkts_d  = wr_pkts_q;
        if (pop) begin
            wr_words_d = wr_words_q + CNT_ONE;
            if (out_last_q) begin
                wr_pkts_d = wr_pkts_q + CNT_ONE;
            end
        end
        // pop already masks wfull, so this only fires if that gating is ever broken.
        err_ovf_d = err_ovf_q | (winc & wfull);
    end

    // Control and counter flops, cleared asynchronously so held words are discarded on reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            wr_words_q   <= '0;
            wr_pkts_q    <= '0;
            err_ovf_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            wr_words_q   <= wr_words_d;
            wr_pkts_q    <= wr_pkts_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    // Data flops carry no reset; their contents are qualified by the valid flags.
    always_ff @(posedge wclk) begin
        out_data_q  <= out_data_d;
        out_last_q  <= out_last_d;
        skid_data_q <= skid_data_d;
        skid_last_q <= skid_last_d;
    end

    assign wr_words = wr_words_q;
    assign wr_pkts  = wr_pkts_q;
    assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_fifo_wr_skid.sv
// Purpose: directed self-checking bench for fifo_wr_skid (default build plus a CNTW=4 build).
// Latency: inputs driven 1ns after wclk rise, outputs sampled 1ns later.
// Backpressure: wfull comes from the bench or from a small write-pointer/full model.
module tb_fifo_wr_skid;

    logic        wclk;
    logic        wrst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        wfull_tb;
    logic        dut_wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [15:0] wr_words;
    logic [15:0] wr_pkts;
    logic        err_ovf;

    // CNTW=4 instance for the wrap case
    logic        w_s_valid;
    logic        w_s_ready;
    logic [7:0]  w_s_data;
    logic        w_s_last;
    logic        w_winc;
    logic [7:0]  w_wdata;
    logic [3:0]  w_wr_words;
    logic [3:0]  w_wr_pkts;
    logic        w_err_ovf;

    // Write-pointer/full stage model, ADDRSIZE=4 (16 entries), read side stalled
    logic        use_model;
    logic        mdl_clr;
    logic [4:0]  mdl_cnt;
    logic        mdl_full;

    int n_vec;
    int n_err;

    fifo_wr_skid #(.DSIZE(8), .CNTW(16)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wfull(dut_wfull), .winc(winc), .wdata(wdata),
        .wr_words(wr_words), .wr_pkts(wr_pkts), .err_ovf(err_ovf)
    );

    fifo_wr_skid #(.DSIZE(8), .CNTW(4)) u_wrap (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data), .s_last(w_s_last),
        .wfull(1'b0), .winc(w_winc), .wdata(w_wdata),
        .wr_words(w_wr_words), .wr_pkts(w_wr_pkts), .err_ovf(w_err_ovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    always_ff @(posedge wclk) begin
        if (mdl_clr) mdl_cnt <= '0;
        else if (winc) mdl_cnt <= mdl_cnt + 5'd1;
    end
    assign mdl_full  = (mdl_cnt == 5'd16);
    assign dut_wfull = use_model ? mdl_full : wfull_tb;

    task automatic next_cycle;
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset;
        wrst_n = 1'b0; s_valid = 1'b1; s_data = 8'h33; s_last = 1'b1; wfull_tb = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        n_vec++; if (winc !== 1'b0) begin n_err++; $display("FAIL reset_winc got %b want 0", winc); end
        n_vec++; if (wr_words !== 16'd0) begin n_err++; $display("FAIL reset_wr_words got %0d want 0", wr_words); end
        n_vec++; if (wr_pkts !== 16'd0) begin n_err++; $display("FAIL reset_wr_pkts got %0d want 0", wr_pkts); end
        n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL reset_err_ovf got %b want 0", err_ovf); end
        n_vec++; if (w_wr_words !== 4'd0 || w_winc !== 1'b0) begin n_err++; $display("FAIL reset_wrap got words=%0d winc=%b want 0/0", w_wr_words, w_winc); end
        s_valid = 1'b0;
        next_cycle();
        wrst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_streaming;
        for (int k = 0; k < 18; k++) begin
            s_valid = (k < 16);
            s_data  = 8'(k + 1);
            s_last  = (k == 15);
            #1;
            n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d got %b want 1", k, s_ready); end
            if (k >= 1 && k <= 16) begin
                n_vec++; if (winc !== 1'b1 || wdata !== 8'(k)) begin n_err++; $display("FAIL stream_word k=%0d got winc=%b wdata=%h want 1/%h", k, winc, wdata, 8'(k)); end
            end else begin
                n_vec++; if (winc !== 1'b0) begin n_err++; $display("FAIL stream_idle k=%0d got winc=%b want 0", k, winc); end
            end
            next_cycle();
        end
        #1;
        n_vec++; if (wr_words !== 16'd16) begin n_err++; $display("FAIL stream_words got %0d want 16", wr_words); end
        n_vec++; if (wr_pkts !== 16'd1) begin n_err++; $display("FAIL stream_pkts got %0d want 1", wr_pkts); end
        next_cycle();
    endtask

    task automatic test_backpressure;
        logic       t_sv[9];
        logic [7:0] t_d[9];
        logic       t_wf[9];
        logic       e_rdy[9];
        logic       e_winc[9];
        logic [7:0] e_wd[9];
        t_sv   = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        t_d    = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'h00, 8'h00};
        t_wf   = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        e_rdy  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        e_winc = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        e_wd   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        for (int c = 0; c < 9; c++) begin
            s_valid = t_sv[c]; s_data = t_d[c]; s_last = (t_d[c] == 8'hA3); wfull_tb = t_wf[c];
            #1;
            n_vec++; if (s_ready !== e_rdy[c]) begin n_err++; $display("FAIL bp_ready c=%0d got %b want %b", c, s_ready, e_rdy[c]); end
            n_vec++; if (winc !== e_winc[c]) begin n_err++; $display("FAIL bp_winc c=%0d got %b want %b", c, winc, e_winc[c]); end
            if (e_winc[c]) begin
                n_vec++; if (wdata !== e_wd[c]) begin n_err++; $display("FAIL bp_wdata c=%0d got %h want %h", c, wdata, e_wd[c]); end
            end
            next_cycle();
        end
        #1;
        n_vec++; if (wr_words !== 16'd20 || wr_pkts !== 16'd2) begin n_err++; $display("FAIL bp_counts got %0d/%0d want 20/2", wr_words, wr_pkts); end
        next_cycle();
    endtask

    task automatic test_simul_accept_pop;
        logic [7:0]  sb[$];
        logic [7:0]  idx;
        logic [7:0]  exp_w;
        logic [15:0] base;
        logic [15:0] diff;
        logic        hs;
        int          pulses;
        idx = 8'h10; pulses = 0; base = wr_words;
        for (int c = 0; c < 24; c++) begin
            s_valid = (c < 20); s_data = idx; s_last = 1'b0;
            wfull_tb = (c < 20) ? c[0] : 1'b0;
            #1;
            if (winc === 1'b1) begin
                pulses++;
                exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                n_vec++; if (wdata !== exp_w) begin n_err++; $display("FAIL simul_order c=%0d got %h want %h", c, wdata, exp_w); end
            end
            hs = s_valid & s_ready;
            if (hs) sb.push_back(s_data);
            next_cycle();
            if (hs) idx = idx + 8'd1;
        end
        #1;
        diff = wr_words - base;
        n_vec++; if (pulses != 11) begin n_err++; $display("FAIL simul_pulses got %0d want 11", pulses); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL simul_leftover got %0d want 0", sb.size()); end
        n_vec++; if (diff !== 16'd11) begin n_err++; $display("FAIL simul_words got %0d want 11", diff); end
        n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL simul_err_ovf got %b want 0", err_ovf); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        wfull_tb = 1'b1; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
        next_cycle();
        s_data = 8'h22;
        next_cycle();
        #1;
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rmid_full got s_ready=%b want 0", s_ready); end
        wrst_n = 1'b0; s_valid = 1'b0; wfull_tb = 1'b0;
        #1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %b want 1", s_ready); end
        n_vec++; if (winc !== 1'b0) begin n_err++; $display("FAIL rmid_winc got %b want 0", winc); end
        n_vec++; if (wr_words !== 16'd0 || wr_pkts !== 16'd0) begin n_err++; $display("FAIL rmid_counts got %0d/%0d want 0/0", wr_words, wr_pkts); end
        next_cycle();
        wrst_n = 1'b1; s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
        #1;
        n_vec++; if (winc !== 1'b0 || s_ready !== 1'b1) begin n_err++; $display("FAIL rmid_release got winc=%b ready=%b want 0/1", winc, s_ready); end
        next_cycle();
        s_valid = 1'b0;
        #1;
        n_vec++; if (winc !== 1'b1 || wdata !== 8'h5A) begin n_err++; $display("FAIL rmid_first got winc=%b wdata=%h want 1/5a", winc, wdata); end
        next_cycle();
        #1;
        n_vec++; if (winc !== 1'b0 || wr_words !== 16'd1 || wr_pkts !== 16'd1) begin n_err++; $display("FAIL rmid_after got winc=%b words=%0d pkts=%0d want 0/1/1", winc, wr_words, wr_pkts); end
        next_cycle();
    endtask

    task automatic test_wrap;
        int pulses;
        pulses = 0;
        for (int k = 0; k < 19; k++) begin
            w_s_valid = (k < 17); w_s_data = 8'(k); w_s_last = 1'b1;
            #1;
            if (w_winc === 1'b1) pulses++;
            next_cycle();
        end
        #1;
        n_vec++; if (pulses != 17) begin n_err++; $display("FAIL wrap_pulses got %0d want 17", pulses); end
        n_vec++; if (w_wr_words !== 4'd1) begin n_err++; $display("FAIL wrap_words got %0d want 1", w_wr_words); end
        n_vec++; if (w_wr_pkts !== 4'd1) begin n_err++; $display("FAIL wrap_pkts got %0d want 1", w_wr_pkts); end
        next_cycle();
    endtask

    task automatic test_integrated;
        logic [7:0]  idx;
        logic [7:0]  exp_w;
        logic [15:0] base;
        logic [15:0] diff;
        logic        hs;
        int          pulses;
        wfull_tb = 1'b0; s_valid = 1'b0; mdl_clr = 1'b1; use_model = 1'b1;
        next_cycle();
        mdl_clr = 1'b0;
        idx = 8'h80; exp_w = 8'h80; pulses = 0; base = wr_words;
        for (int c = 0; c < 25; c++) begin
            s_valid = 1'b1; s_data = idx; s_last = 1'b0;
            #1;
            if (winc === 1'b1) begin
                pulses++;
                n_vec++; if (wdata !== exp_w) begin n_err++; $display("FAIL integ_order c=%0d got %h want %h", c, wdata, exp_w); end
                exp_w = exp_w + 8'd1;
            end
            hs = s_valid & s_ready;
            next_cycle();
            if (hs) idx = idx + 8'd1;
        end
        #1;
        diff = wr_words - base;
        n_vec++; if (pulses != 16) begin n_err++; $display("FAIL integ_pulses got %0d want 16", pulses); end
        n_vec++; if (diff !== 16'd16) begin n_err++; $display("FAIL integ_words got %0d want 16", diff); end
        n_vec++; if (dut_wfull !== 1'b1 || winc !== 1'b0) begin n_err++; $display("FAIL integ_full got wfull=%b winc=%b want 1/0", dut_wfull, winc); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL integ_ready got %b want 0", s_ready); end
        n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL integ_err_ovf got %b want 0", err_ovf); end
        s_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        use_model = 1'b0; mdl_clr = 1'b1;
        w_s_valid = 1'b0; w_s_data = 8'h00; w_s_last = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; wfull_tb = 1'b0; wrst_n = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simul_accept_pop();
        test_reset_mid();
        test_wrap();
        test_integrated();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
